// File: rtl/mgmt_framer_pkg.sv
// Shared types and constants for the management UART command framer.
package mgmt_framer_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    OPCODE,
    LENGTH,
    PAYLOAD,
    CHECKSUM,
    HOLD
  } state_t;

endpackage

// File: rtl/mgmt_uart_framer_if.sv
// Byte stream in, held command and payload read port out.
interface mgmt_uart_framer_if #(
  parameter int MAX_PAYLOAD = 16
);
  localparam int AW = $clog2(MAX_PAYLOAD);

  logic [7:0]    rx_data;
  logic          rx_en;
  logic          cmd_valid;
  logic [7:0]    cmd_opcode;
  logic [7:0]    cmd_len;
  logic [AW-1:0] cmd_rd_addr;
  logic [7:0]    cmd_rd_data;
  logic          cmd_ack;

  modport master (
    input  rx_data, rx_en, cmd_rd_addr, cmd_ack,
    output cmd_valid, cmd_opcode, cmd_len, cmd_rd_data
  );

  modport slave (
    output rx_data, rx_en, cmd_rd_addr, cmd_ack,
    input  cmd_valid, cmd_opcode, cmd_len, cmd_rd_data
  );
endinterface

// File: rtl/mgmt_sat_counter.sv
// Error-event counter that sticks at all-ones instead of wrapping.
module mgmt_sat_counter
  import mgmt_framer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mgmt_uart_framer.sv
// Hunts for SYNC_BYTE, collects opcode/length/payload/checksum and holds each
// validated frame as one command until acknowledged.
module mgmt_uart_framer
  import mgmt_framer_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         TIMEOUT_CYCLES = 250000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  mgmt_uart_framer_if.master  bus,
  output logic [CNT_W-1:0]    err_checksum,
  output logic [CNT_W-1:0]    err_length,
  output logic [CNT_W-1:0]    err_timeout,
  output logic [CNT_W-1:0]    err_overrun
);

  localparam int            AW      = $clog2(MAX_PAYLOAD);
  localparam int            TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]    MAX_LEN = 8'(MAX_PAYLOAD);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  logic [7:0]    opcode_q, len_q, csum_q, idx_q;
  logic [TW-1:0] tcnt;
  logic [7:0]    pay_mem [MAX_PAYLOAD];
  logic          in_frame, timed_out;
  logic          pay_we, accept, inc_ck, inc_len, inc_to, inc_ovr;

  assign in_frame  = state inside {OPCODE, LENGTH, PAYLOAD, CHECKSUM};
  // A byte arriving on the last allowed cycle still wins over the timeout.
  assign timed_out = in_frame && !bus.rx_en && (tcnt == T_LAST);
  assign bus.cmd_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pay_we    = 1'b0;
    accept    = 1'b0;
    inc_ck    = 1'b0;
    inc_len   = 1'b0;
    inc_to    = 1'b0;
    inc_ovr   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_en && (bus.rx_data == SYNC_BYTE)) state_nxt = OPCODE;
      end
      OPCODE: begin
        if (bus.rx_en) state_nxt = LENGTH;
      end
      LENGTH: begin
        if (bus.rx_en) begin
          if (bus.rx_data > MAX_LEN) begin
            inc_len   = 1'b1;
            state_nxt = IDLE;
          end else if (bus.rx_data == 8'd0) begin
            state_nxt = CHECKSUM;
          end else begin
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (bus.rx_en) begin
          pay_we = 1'b1;
          if ((idx_q + 8'd1) == len_q) state_nxt = CHECKSUM;
        end
      end
      CHECKSUM: begin
        if (bus.rx_en) begin
          if (bus.rx_data == csum_q) begin
            accept    = 1'b1;
            state_nxt = HOLD;
          end else begin
            inc_ck    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      HOLD: begin
        inc_ovr = bus.rx_en;
        if (bus.cmd_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (timed_out) begin
      inc_to    = 1'b1;
      state_nxt = IDLE;
    end
  end

  // Inter-byte gap counter, live only while a frame is being collected.
  always_ff @(posedge clk) begin
    if (!rst_n || !in_frame || bus.rx_en || timed_out) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.rx_en) begin
      case (state)
        OPCODE: begin
          opcode_q <= bus.rx_data;
          csum_q   <= bus.rx_data;
        end
        LENGTH: begin
          len_q  <= bus.rx_data;
          csum_q <= csum_q ^ bus.rx_data;
          idx_q  <= 8'd0;
        end
        PAYLOAD: begin
          csum_q <= csum_q ^ bus.rx_data;
          idx_q  <= idx_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pay_we) pay_mem[idx_q[AW-1:0]] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.cmd_opcode  <= 8'd0;
      bus.cmd_len     <= 8'd0;
      bus.cmd_rd_data <= 8'd0;
    end else begin
      if (accept) begin
        bus.cmd_opcode <= opcode_q;
        bus.cmd_len    <= len_q;
      end
      bus.cmd_rd_data <= pay_mem[bus.cmd_rd_addr];
    end
  end

  mgmt_sat_counter u_err_checksum (.clk(clk), .rst_n(rst_n), .inc(inc_ck),  .count(err_checksum));
  mgmt_sat_counter u_err_length   (.clk(clk), .rst_n(rst_n), .inc(inc_len), .count(err_length));
  mgmt_sat_counter u_err_timeout  (.clk(clk), .rst_n(rst_n), .inc(inc_to),  .count(err_timeout));
  mgmt_sat_counter u_err_overrun  (.clk(clk), .rst_n(rst_n), .inc(inc_ovr), .count(err_overrun));

endmodule

// File: tb/tb_mgmt_uart_framer.sv
// Randomized bench for mgmt_uart_framer with a frame-level reference model.
module tb_mgmt_uart_framer;

  localparam int MAXP = 16;
  localparam int TO   = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mgmt_uart_framer_if #(.MAX_PAYLOAD(MAXP)) ifc ();
  logic [15:0] err_checksum, err_length, err_timeout, err_overrun;

  mgmt_uart_framer #(
    .MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .err_checksum(err_checksum), .err_length(err_length),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: frame bytes kept in a queue ----------------
  bit          m_hold = 0, m_in = 0, m_rd_ok = 0, cmp_en = 0;
  logic [7:0]  mq[$];
  int          m_gap = 0, m_n = 0;
  logic [7:0]  m_op = 0, m_len = 0, m_x = 0, m_rd_exp = 0;
  logic [7:0]  m_pay [MAXP];
  logic [15:0] m_ck = 0, m_ln = 0, m_to = 0, m_ov = 0;

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always @(posedge clk) begin
    m_rd_ok  = m_hold && (int'(ifc.cmd_rd_addr) < int'(m_len));
    m_rd_exp = m_pay[ifc.cmd_rd_addr];
    if (!rst_n) begin
      m_hold = 0; m_in = 0; m_gap = 0; mq.delete(); m_rd_ok = 0;
      m_ck = 0; m_ln = 0; m_to = 0; m_ov = 0;
    end else if (m_hold) begin
      if (ifc.rx_en) m_ov = sat(m_ov);
      if (ifc.cmd_ack) m_hold = 0;
    end else if (m_in) begin
      if (ifc.rx_en) begin
        mq.push_back(ifc.rx_data);
        m_gap = 0;
        m_n = mq.size();
        if (m_n == 2 && int'(mq[1]) > MAXP) begin
          m_ln = sat(m_ln); m_in = 0;
        end else if (m_n >= 2 && m_n == int'(mq[1]) + 3) begin
          m_x = 8'd0;
          for (int i = 0; i < m_n - 1; i++) m_x ^= mq[i];
          if (m_x == mq[m_n-1]) begin
            m_hold = 1; m_op = mq[0]; m_len = mq[1];
            for (int i = 0; i < int'(mq[1]); i++) m_pay[i] = mq[2+i];
          end else begin
            m_ck = sat(m_ck);
          end
          m_in = 0;
        end
      end else if (m_gap == TO - 1) begin
        m_in = 0; m_to = sat(m_to);
      end else begin
        m_gap++;
      end
    end else if (ifc.rx_en && ifc.rx_data == 8'hA5) begin
      m_in = 1; mq.delete(); m_gap = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmd_valid", 32'(ifc.cmd_valid), 32'(m_hold));
      if (m_hold) begin
        chk("cmd_opcode", 32'(ifc.cmd_opcode), 32'(m_op));
        chk("cmd_len", 32'(ifc.cmd_len), 32'(m_len));
      end
      if (m_rd_ok) chk("cmd_rd_data", 32'(ifc.cmd_rd_data), 32'(m_rd_exp));
      chk("err_checksum", 32'(err_checksum), 32'(m_ck));
      chk("err_length", 32'(err_length), 32'(m_ln));
      chk("err_timeout", 32'(err_timeout), 32'(m_to));
      chk("err_overrun", 32'(err_overrun), 32'(m_ov));
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic send_b(input logic [7:0] b, input int gap, input bit with_ack = 1'b0);
    ifc.rx_en = 1'b1; ifc.rx_data = b; ifc.cmd_ack = with_ack;
    @(negedge clk);
    ifc.rx_en = 1'b0; ifc.cmd_ack = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_ack();
    ifc.cmd_ack = 1'b1;
    @(negedge clk);
    ifc.cmd_ack = 1'b0;
  endtask

  function automatic int rgap();
    if ($urandom_range(0, 9) == 0) return $urandom_range(TO - 2, TO + 1);
    return $urandom_range(0, 2);
  endfunction

  task automatic send_frame(input logic [7:0] op, input int len, input bit bad, input bit gaps);
    logic [7:0] cs, b;
    cs = op ^ 8'(len);
    send_b(8'hA5, gaps ? rgap() : 0);
    send_b(op, gaps ? rgap() : 0);
    send_b(8'(len), gaps ? rgap() : 0);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      cs ^= b;
      send_b(b, gaps ? rgap() : 0);
    end
    if (bad) cs ^= 8'(1 << $urandom_range(0, 7));
    send_b(cs, 0);
  endtask

  task automatic good_10_3();
    send_b(8'hA5, 0); send_b(8'h10, 0); send_b(8'h03, 0);
    send_b(8'h11, 0); send_b(8'h22, 0); send_b(8'h33, 0); send_b(8'h13, 0);
  endtask

  logic [7:0] exp3 [3];
  int kind;

  initial begin
    exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
    ifc.rx_en = 1'b0; ifc.rx_data = 8'h00; ifc.cmd_ack = 1'b0; ifc.cmd_rd_addr = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset cmd_valid", 32'(ifc.cmd_valid), 32'd0);
    chk("reset cmd_opcode", 32'(ifc.cmd_opcode), 32'd0);
    chk("reset cmd_len", 32'(ifc.cmd_len), 32'd0);
    chk("reset cmd_rd_data", 32'(ifc.cmd_rd_data), 32'd0);
    chk("reset counters", 32'(err_checksum | err_length | err_timeout | err_overrun), 32'd0);
    cmp_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // good frame
    good_10_3();
    chk("good valid", 32'(ifc.cmd_valid), 32'd1);
    chk("good opcode", 32'(ifc.cmd_opcode), 32'h10);
    chk("good len", 32'(ifc.cmd_len), 32'd3);
    for (int i = 0; i < 3; i++) begin
      ifc.cmd_rd_addr = 4'(i);
      @(negedge clk);
      chk("good payload", 32'(ifc.cmd_rd_data), 32'(exp3[i]));
    end
    chk("good counters", 32'(err_checksum | err_length | err_timeout | err_overrun), 32'd0);
    do_ack();
    chk("ack drops valid", 32'(ifc.cmd_valid), 32'd0);

    // zero-length frame, then garbage outside a frame
    send_b(8'hA5, 0); send_b(8'h7E, 0); send_b(8'h00, 0); send_b(8'h7E, 0);
    chk("zero-len valid", 32'(ifc.cmd_valid), 32'd1);
    chk("zero-len len", 32'(ifc.cmd_len), 32'd0);
    do_ack();
    send_b(8'h00, 1); send_b(8'hFF, 1);
    chk("garbage counters", 32'(err_checksum | err_length | err_timeout | err_overrun), 32'd0);

    // bad checksum, then a good frame
    send_b(8'hA5, 0); send_b(8'h01, 0); send_b(8'h01, 0); send_b(8'hAA, 0); send_b(8'h00, 0);
    chk("bad csum count", 32'(err_checksum), 32'd1);
    chk("bad csum valid", 32'(ifc.cmd_valid), 32'd0);
    good_10_3();
    chk("after bad csum valid", 32'(ifc.cmd_valid), 32'd1);
    do_ack();

    // bad length; the next sync starts a fresh frame
    send_b(8'hA5, 0); send_b(8'h01, 0); send_b(8'h11, 0);
    chk("bad len count", 32'(err_length), 32'd1);
    send_b(8'hA5, 0); send_b(8'h02, 0); send_b(8'h00, 0); send_b(8'h02, 0);
    chk("after bad len valid", 32'(ifc.cmd_valid), 32'd1);
    chk("after bad len opcode", 32'(ifc.cmd_opcode), 32'h02);
    do_ack();

    // timeout after TO silent cycles; a TO-1 gap survives
    send_b(8'hA5, 0); send_b(8'h01, TO);
    chk("timeout count", 32'(err_timeout), 32'd1);
    send_b(8'hA5, 0); send_b(8'h01, TO - 1); send_b(8'h00, TO - 2); send_b(8'h01, 0);
    chk("long gap no timeout", 32'(err_timeout), 32'd1);
    chk("long gap valid", 32'(ifc.cmd_valid), 32'd1);
    do_ack();

    // overrun while held, then ack together with a byte
    good_10_3();
    send_b(8'hA5, 0); send_b(8'h10, 0); send_b(8'h5A, 0);
    chk("overrun 3", 32'(err_overrun), 32'd3);
    chk("overrun keeps opcode", 32'(ifc.cmd_opcode), 32'h10);
    chk("overrun keeps len", 32'(ifc.cmd_len), 32'd3);
    send_b(8'h55, 0, 1'b1);
    chk("overrun 4", 32'(err_overrun), 32'd4);
    chk("ack+byte valid", 32'(ifc.cmd_valid), 32'd0);

    // drive the overrun counter into saturation
    good_10_3();
    ifc.rx_en = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      ifc.rx_data = 8'($urandom);
      @(negedge clk);
    end
    ifc.rx_en = 1'b0;
    chk("overrun saturated", 32'(err_overrun), 32'hFFFF);
    send_b(8'h00, 0);
    chk("overrun stays", 32'(err_overrun), 32'hFFFF);
    do_ack();

    // randomized traffic
    for (int it = 0; it < 200; it++) begin
      kind = $urandom_range(0, 11);
      if (kind <= 5) begin
        send_frame(8'($urandom), $urandom_range(0, MAXP), 1'b0, kind >= 4);
      end else if (kind == 6) begin
        send_frame(8'($urandom), $urandom_range(0, MAXP), 1'b1, 1'b0);
      end else if (kind == 7) begin
        send_b(8'hA5, rgap()); send_b(8'($urandom), rgap());
        send_b(8'($urandom_range(MAXP + 1, 255)), rgap());
      end else if (kind == 8) begin
        repeat ($urandom_range(1, 5)) send_b(8'($urandom), rgap());
      end else if (kind == 9) begin
        send_b(8'hA5, 0); send_b(8'($urandom), 0);
        repeat (TO + 2) @(negedge clk);
      end else if (kind == 10) begin
        send_b(8'hA5, 0); send_b(8'($urandom), 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end else begin
        do_ack();
      end
      if (m_hold) begin
        repeat ($urandom_range(1, 5)) begin
          ifc.cmd_rd_addr = 4'($urandom);
          @(negedge clk);
        end
        repeat ($urandom_range(0, 2)) send_b(8'($urandom), 0);
        if ($urandom_range(0, 1) == 1) send_b(8'($urandom), 0, 1'b1);
        else do_ack();
      end
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mgmt_uart_framer.md
# mgmt_uart_framer

Byte-to-command framing stage between the 115200-baud UART receiver (clk_25mhz domain) and the management controller's command decoder. It hunts for a sync byte, collects opcode, length, payload and checksum, and validates the frame. Each good frame is presented to the controller as one held command with a random-access payload buffer. Malformed, truncated and overrun traffic is dropped and counted in saturating error counters.

## Interface
Parameters:
- MAX_PAYLOAD, 16: payload buffer depth in bytes; legal lengths are 0..MAX_PAYLOAD.
- TIMEOUT_CYCLES, 250000: inter-byte timeout in clk cycles (10 ms at 25 MHz).
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock; one clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- rx_data  in  8  byte from UART receiver; valid only when rx_en is high.
- rx_en  in  1  single-cycle strobe, one per received byte.
- cmd_valid  out  1  a validated command is held; level signal until acknowledged.
- cmd_opcode  out  8  opcode of the held command.
- cmd_len  out  8  payload length of the held command.
- cmd_rd_addr  in  $clog2(MAX_PAYLOAD)  payload buffer read address.
- cmd_rd_data  out  8  payload byte, registered, 1-cycle read latency.
- cmd_ack  in  1  consumer releases the held command.
- err_checksum  out  16  count of checksum failures.
- err_length  out  16  count of frames with length > MAX_PAYLOAD.
- err_timeout  out  16  count of frames aborted by the inter-byte timeout.
- err_overrun  out  16  count of bytes dropped while a command is held.

## Operation
- Frame format: SYNC_BYTE, opcode, length, then `length` payload bytes, then a checksum.
- Checksum is the XOR of opcode, length and all payload bytes. It is 8 bits wide and does not include sync.
- FSM states:
  - IDLE: rx_en with SYNC_BYTE goes to OPCODE. Any other byte is discarded silently, with no counter change.
  - OPCODE: latch the opcode and seed the running XOR; go to LENGTH.
  - LENGTH:
    - length > MAX_PAYLOAD: err_length++, back to IDLE.
    - length == 0: go to CHECKSUM.
    - otherwise: go to PAYLOAD.
  - PAYLOAD: write each byte to the buffer at an incrementing index starting at 0. After the `length`th byte, go to CHECKSUM.
  - CHECKSUM:
    - match: go to HOLD and assert cmd_valid.
    - mismatch: err_checksum++, back to IDLE.
  - HOLD: cmd_valid, cmd_opcode, cmd_len and the buffer contents are frozen. Every rx_en in this state increments err_overrun and the byte is dropped. cmd_ack moves the FSM to IDLE.
- Timeout:
  - A counter clears on every accepted rx_en and counts while in OPCODE, LENGTH, PAYLOAD or CHECKSUM.
  - On reaching TIMEOUT_CYCLES-1, the FSM returns to IDLE and err_timeout++.
  - The counter is idle in IDLE and HOLD.
- cmd_ack outside HOLD is ignored.
- A SYNC_BYTE value inside a frame is ordinary data; there is no resync mid-frame.
- All error counters saturate at 16'hFFFF.
- Buffer locations at or above cmd_len return stale data.

## Timing
- Reset values: cmd_valid=0, cmd_opcode=0, cmd_len=0, cmd_rd_data=0, all err_* = 0, FSM=IDLE, timeout counter=0. Reset mid-frame or during HOLD discards everything.
- cmd_valid rises on the clock edge after the checksum byte's rx_en cycle (1-cycle latency).
- cmd_ack sampled high in HOLD: cmd_valid is low on the next cycle, and a byte arriving on that next cycle is accepted normally from IDLE.
- rx_en in the same cycle as cmd_ack: the byte is dropped and counted as an overrun.
- Error counters update on the clock edge after the triggering cycle.
- cmd_rd_data reflects cmd_rd_addr from the previous cycle.

## Structure
- mgmt_framer_pkg holds the FSM state enum (IDLE, OPCODE, LENGTH, PAYLOAD, CHECKSUM, HOLD) and the counter width constant (16).
- Sub-module mgmt_sat_counter, a 16-bit saturating incrementer with sync active-low reset, is instantiated four times.
- The payload buffer is an inferred MAX_PAYLOAD×8 register array inside the framer.

## Test plan
- Good frame: A5 10 03 11 22 33 then checksum 0x10^0x03^0x11^0x22^0x33 = 0x13. Expect cmd_valid one cycle after the last byte, opcode 0x10, len 3, reads of addr 0..2 giving 11 22 33, all counters 0.
- Zero-length frame: A5 7E 00 7E. Expect cmd_valid, cmd_len 0. Then garbage bytes 00 FF before the next A5 leave all counters at 0.
- Bad checksum: A5 01 01 AA 00. Expect err_checksum=1 and no cmd_valid. A following good frame is accepted.
- Bad length: A5 01 11 with MAX_PAYLOAD=16. Expect err_length=1 and FSM in IDLE; the next byte A5 starts a new frame.
- Timeout: A5 01 then silence for TIMEOUT_CYCLES. Expect err_timeout=1, then a good frame is accepted. A gap of TIMEOUT_CYCLES-2 must not time out.
- Overrun: hold a command without ack and send 3 bytes. Expect err_overrun=3 and cmd_* unchanged. Pulse cmd_ack together with a 4th byte: err_overrun=4 and cmd_valid low next cycle. Separately, force the counter to FFFF and confirm it stays at FFFF.
